// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: request/write payload in, grant and read response out.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port memory between two requesters.
// Optional ARB_ADDR_CHECK_EN: out-of-range accesses are blocked and answered with err.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 64,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [DW-1:0] mem_rdata_i
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q;
    logic          last_q;
    logic [HW-1:0] hold_q;
    logic          rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          win1, any, gnt0, gnt1, sel_we, addr_bad, resp;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    state_t        win_state;

    // win1 picks m1; only meaningful when someone requests
    always_comb begin
        win1 = m1.req;
        if (m0.req && m1.req) begin
            unique case (state_q)
                OWN0:    win1 = (hold_q == HOLD_MAX);
                OWN1:    win1 = (hold_q != HOLD_MAX);
                default: win1 = ~last_q;
            endcase
        end
    end

    assign any       = rst & (m0.req | m1.req);
    assign gnt0      = any & ~win1;
    assign gnt1      = any & win1;
    assign sel_we    = win1 ? m1.we : m0.we;
    assign sel_addr  = any ? (win1 ? m1.addr : m0.addr) : '0;
    assign sel_wdata = any ? (win1 ? m1.wdata : m0.wdata) : '0;
    assign win_state = win1 ? OWN1 : OWN0;

`ifdef ARB_ADDR_CHECK_EN
    assign addr_bad = any & (sel_addr >= AW'(DEPTH));
`else
    assign addr_bad = 1'b0;
`endif

    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;
    assign mem_we_o    = any & sel_we & ~addr_bad;
    assign mem_re_o    = any & ~sel_we & ~addr_bad;
    // a response is owed for every granted read and every rejected access
    assign resp        = any & (~sel_we | addr_bad);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 & resp;
            rvalid1_q <= gnt1 & resp;
            err0_q    <= gnt0 & addr_bad;
            err1_q    <= gnt1 & addr_bad;
            if (gnt0 & resp) rdata0_q <= addr_bad ? '0 : mem_rdata_i;
            if (gnt1 & resp) rdata1_q <= addr_bad ? '0 : mem_rdata_i;
            if (any) begin
                state_q <= win_state;
                last_q  <= win1;
                if (state_q == win_state)
                    hold_q <= (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
                else
                    hold_q <= HW'(1);
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
    assign m0.err    = err0_q;
    assign m1.err    = err1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules and memory contents.
module tb_mem_arbiter;
    localparam int MAXH = 4;

    logic        clk, rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    mem_arbiter_if #(.AW(32), .DW(32)) i0 ();
    mem_arbiter_if #(.AW(32), .DW(32)) i1 ();

    mem_arbiter #(.AW(32), .DW(32), .DEPTH(64), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .m0(i0), .m1(i1),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory stand-in, preloaded with mem[i] = i on the first edge
    logic [31:0] mem [64];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= i;
            loaded <= 1'b1;
        end else if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    typedef struct packed { logic req, we; logic [31:0] addr, wdata; } req_t;
    typedef struct { int n; logic g0, g1, we, re; logic [31:0] addr, wdata; } gexp_t;
    typedef struct { int due; logic [31:0] data; logic err; } rexp_t;

    gexp_t gq[$];
    rexp_t r0q[$], r1q[$];
    int    n_cmp = 0, n_bad = 0, ncyc = 0;
    bit    chk_en = 0;

    // model: current owner (-1 none), length of its current run, last owner, memory image
    int          cur = -1, run = 0;
    int          last = 1;
    logic [31:0] rmem [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int predict(input req_t a, input req_t b);
        if (!a.req && !b.req) return -1;
        if (a.req != b.req)   return a.req ? 0 : 1;
        if (cur < 0)          return 1 - last;
        if (run >= MAXH)      return 1 - cur;
        return cur;
    endfunction

    task automatic cycle(input req_t a, input req_t b, output int w);
        gexp_t e;
        rexp_t r;
        req_t  s;
        logic  bad;
        @(negedge clk);
        i0.req = a.req; i0.we = a.we; i0.addr = a.addr; i0.wdata = a.wdata;
        i1.req = b.req; i1.we = b.we; i1.addr = b.addr; i1.wdata = b.wdata;
        w = predict(a, b);
        e = '{n: ncyc, g0: w == 0, g1: w == 1, we: 0, re: 0, addr: 0, wdata: 0};
        if (w >= 0) begin
            s = (w == 0) ? a : b;
`ifdef ARB_ADDR_CHECK_EN
            bad = (s.addr >= 64);
`else
            bad = 1'b0;
`endif
            e.we = s.we & ~bad; e.re = ~s.we & ~bad;
            e.addr = s.addr; e.wdata = s.wdata;
            if (!s.we || bad) begin
                r = '{due: ncyc + 1, data: bad ? 32'h0 : rmem[s.addr % 64], err: bad};
                if (w == 0) r0q.push_back(r); else r1q.push_back(r);
            end
            if (s.we && !bad) rmem[s.addr % 64] = s.wdata;
            run = (w == cur) ? run + 1 : 1;
            cur = w; last = w;
        end else cur = -1;
        gq.push_back(e);
        ncyc++;
    endtask

    // monitor: compares DUT outputs against queued expectations, mid-cycle
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk); #3;
            if (chk_en && gq.size() > 0) begin
                e = gq.pop_front();
                chk("m0_gnt", i0.gnt, e.g0);
                chk("m1_gnt", i1.gnt, e.g1);
                chk("mem_we", mem_we, e.we);
                chk("mem_re", mem_re, e.re);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wdata", mem_wdata, e.wdata);
                if (i0.rvalid) begin
                    if (r0q.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
                    else begin
                        r = r0q.pop_front();
                        chk("m0_rvalid_cycle", e.n, r.due);
                        chk("m0_rdata", i0.rdata, r.data);
                        chk("m0_err", i0.err, r.err);
                    end
                end else begin
                    chk("m0_err_idle", i0.err, 0);
                    if (r0q.size() > 0 && r0q[0].due <= e.n) begin
                        chk("m0_rvalid_missing", 0, 1);
                        void'(r0q.pop_front());
                    end
                end
                if (i1.rvalid) begin
                    if (r1q.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
                    else begin
                        r = r1q.pop_front();
                        chk("m1_rvalid_cycle", e.n, r.due);
                        chk("m1_rdata", i1.rdata, r.data);
                        chk("m1_err", i1.err, r.err);
                    end
                end else begin
                    chk("m1_err_idle", i1.err, 0);
                    if (r1q.size() > 0 && r1q[0].due <= e.n) begin
                        chk("m1_rvalid_missing", 0, 1);
                        void'(r1q.pop_front());
                    end
                end
            end
        end
    end

    function automatic req_t rq(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        req_t t;
        t.req = 1'b1; t.we = we; t.addr = addr; t.wdata = wd;
        return t;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_m0_gnt"}, i0.gnt, 0);
        chk({tag, "_m1_gnt"}, i1.gnt, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_m0_rvalid"}, i0.rvalid, 0);
        chk({tag, "_m1_rvalid"}, i1.rvalid, 0);
        chk({tag, "_m0_err"}, i0.err, 0);
        chk({tag, "_m1_err"}, i1.err, 0);
        chk({tag, "_m0_rdata"}, i0.rdata, 0);
        chk({tag, "_m1_rdata"}, i1.rdata, 0);
    endtask

    initial begin
        req_t        idle, a, b;
        int          w, prev_w;
        logic [11:0] seq;
        logic [5:0]  s4;

        idle = '0;
        for (int i = 0; i < 64; i++) rmem[i] = i;
        rst = 1'b0;
        i0.req = 1; i0.we = 0; i0.addr = 7; i0.wdata = 0;
        i1.req = 1; i1.we = 1; i1.addr = 9; i1.wdata = 1;
        #22;
        check_quiet("reset");
        @(negedge clk);
        i0.req = 0; i1.req = 0;
        rst = 1'b1;
        chk_en = 1;

        // both requesters contend from reset: runs of MAX_HOLD alternate
        for (int k = 0; k < 12; k++) begin
            cycle(rq(0, 10, 0), rq(0, 20, 0), w);
            #2; seq[11-k] = i1.gnt;
            chk("t3_one_grant", i0.gnt ^ i1.gnt, 1);
        end
        chk("t3_sequence", seq, 12'h0F0);

        // asynchronous reset mid-run, reads still in flight
        #2; rst = 1'b0; #1;
        chk_en = 0;
        check_quiet("midrst");
        gq.delete(); r0q.delete(); r1q.delete();
        cur = -1; run = 0; last = 1;
        @(negedge clk);
        i0.req = 0; i1.req = 0;
        rst = 1'b1;
        chk_en = 1;

        // contested read/write to the same word right after reset
        cycle(rq(0, 3, 0), rq(1, 3, 32'h77), w);
        #2; chk("t5_m0_first", i0.gnt, 1);
        cycle(idle, rq(1, 3, 32'h77), w);
        #2; chk("t5_m1_next", i1.gnt, 1);
        chk("t5_m0_rdata_old", i0.rdata, 3);
        cycle(rq(0, 3, 0), idle, w);
        cycle(idle, idle, w);
        #2; chk("t5_m0_rdata_new", i0.rdata, 32'h77);

        // write then read back
        cycle(rq(1, 5, 32'hA5), idle, w);
        #2; chk("t2_gnt", i0.gnt, 1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 5);
        cycle(rq(0, 5, 0), idle, w);
        cycle(idle, idle, w);
        #2; chk("t2_rvalid", i0.rvalid, 1);
        chk("t2_rdata", i0.rdata, 32'hA5);

        // uncontested m1 burst, then m0 joins
        for (int k = 0; k < 6; k++) begin
            cycle(idle, rq(0, 40 + k, 0), w);
            #2; s4[k] = i1.gnt;
        end
        chk("t4_m1_burst", s4, 6'h3F);
        cycle(rq(0, 1, 0), rq(0, 2, 0), w);
        #2; chk("t4_m0_joins", i0.gnt, 1);
        cycle(idle, idle, w);

`ifdef ARB_ADDR_CHECK_EN
        cycle(idle, rq(1, 64, 32'hDEAD), w);
        #2; chk("t6_mem_we", mem_we, 0);
        cycle(idle, rq(0, 64, 0), w);
        #2; chk("t6_rvalid", i1.rvalid, 1);
        chk("t6_err", i1.err, 1);
        cycle(rq(0, 0, 0), idle, w);
        cycle(idle, idle, w);
        #2; chk("t6_mem0", i0.rdata, 0);
`endif

        // random traffic; a pending request is held until granted or occasionally withdrawn
        a = idle; b = idle; prev_w = -1;
        for (int k = 0; k < 1500; k++) begin
            if (!a.req || prev_w == 0) begin
                a = idle;
                if ($urandom_range(9) < 7)
                    a = rq(1'($urandom), ($urandom_range(7) == 0) ? $urandom : $urandom_range(63), $urandom);
            end else if ($urandom_range(15) == 0) a = idle;
            if (!b.req || prev_w == 1) begin
                b = idle;
                if ($urandom_range(9) < 7)
                    b = rq(1'($urandom), ($urandom_range(7) == 0) ? $urandom : $urandom_range(63), $urandom);
            end else if ($urandom_range(15) == 0) b = idle;
            cycle(a, b, w);
            prev_w = w;
        end
        cycle(idle, idle, w);
        cycle(idle, idle, w);
        #4;
        chk("drain_m0", r0q.size(), 0);
        chk("drain_m1", r1q.size(), 0);
        chk("drain_g", gq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
